// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port between producer A (pipeline
//   writeback) and producer B (multi-cycle mult/div unit). A has fixed
//   priority. A saturating counter of consecutive B-stall cycles forces B to
//   win once it reaches STARVE_LIMIT. The granted write is registered for one
//   cycle and then driven onto the register-file write port.
//
//   Optional feature, selected by the macro RF_WRITE_ARB_BYPASS_EN:
//     Adds byp_raddr1/byp_raddr2 inputs and byp_hit1/byp_hit2 outputs. These
//     flag when a decode read port matches the write that is on the port this
//     cycle, so decode can forward rf_wdata. Without the macro those ports and
//     that logic are absent.
//
// Handshake (valid/ready, applies to both A and B):
//   A transfer happens on a rising edge where valid && ready are both high.
//   ready is combinational from the starvation counter and the other side's
//   valid. It never depends on the requester's own valid. A requester that
//   is holding valid high without ready must keep addr/data stable.

module rf_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_src_b,
  output logic [CNT_W-1:0]  starve_cnt
`ifdef RF_WRITE_ARB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] byp_raddr1,
  input  logic [ADDR_W-1:0] byp_raddr2,
  output logic              byp_hit1,
  output logic              byp_hit2
`endif
);

  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  logic              rf_we_q,      rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q,   rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q,   rf_wdata_d;
  logic              rf_src_b_q,   rf_src_b_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

  logic              force_b;
  logic              a_acc;
  logic              b_acc;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Grant decision: A wins by default, and B wins once the counter has saturated.
  always_comb begin
    force_b  = (starve_cnt_q == LIMIT);
    a_ready  = ~force_b | ~b_valid;
    b_ready  = ~a_valid | force_b;
    a_acc    = a_valid & a_ready;
    b_acc    = b_valid & b_ready;
    win_addr = b_acc ? b_addr : a_addr;
    win_data = b_acc ? b_data : a_data;
  end

  // Next-state for the registered write port and the starvation counter.
  always_comb begin
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    rf_src_b_d   = rf_src_b_q;
    starve_cnt_d = starve_cnt_q;

    if (a_acc || b_acc) begin
      // Register 0 is hardwired; accept the write but never enable it.
      rf_we_d    = (win_addr != ZERO_ADDR);
      rf_waddr_d = win_addr;
      rf_wdata_d = win_data;
      rf_src_b_d = b_acc;
    end

    if (b_valid && !b_ready) begin
      if (starve_cnt_q != LIMIT) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end else begin
      starve_cnt_d = '0;
    end
  end

  // State registers. An asynchronous reset drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      rf_src_b_q   <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_src_b_q   <= rf_src_b_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Drive the registered values onto the output ports.
  always_comb begin
    rf_we      = rf_we_q;
    rf_waddr   = rf_waddr_q;
    rf_wdata   = rf_wdata_q;
    rf_src_b   = rf_src_b_q;
    starve_cnt = starve_cnt_q;
  end

`ifdef RF_WRITE_ARB_BYPASS_EN
  // Forwarding hit detection. rf_we is never set for register 0, so register 0 never hits.
  always_comb begin
    byp_hit1 = rf_we_q && (rf_waddr_q == byp_raddr1) && (byp_raddr1 != ZERO_ADDR);
    byp_hit2 = rf_we_q && (rf_waddr_q == byp_raddr2) && (byp_raddr2 != ZERO_ADDR);
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
//   Directed bench for rf_write_arbiter (default parameters, STARVE_LIMIT=4).
//   Inputs change 1 time unit after a rising edge. Combinational readies are
//   checked before the next edge. Registered outputs are checked 1 time unit
//   after that edge.
`timescale 1ns/1ps

module tb_rf_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst_n;
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_src_b;
  logic [CNT_W-1:0]  starve_cnt;
`ifdef RF_WRITE_ARB_BYPASS_EN
  logic [ADDR_W-1:0] byp_raddr1;
  logic [ADDR_W-1:0] byp_raddr2;
  logic              byp_hit1;
  logic              byp_hit2;
`endif

  int errors = 0;
  int checks = 0;

  rf_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(4), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_src_b   (rf_src_b),
    .starve_cnt (starve_cnt)
`ifdef RF_WRITE_ARB_BYPASS_EN
    ,
    .byp_raddr1 (byp_raddr1),
    .byp_raddr2 (byp_raddr2),
    .byp_hit1   (byp_hit1),
    .byp_hit2   (byp_hit2)
`endif
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester obligation: a stalled request that stays valid keeps addr/data stable.
  logic              a_stall_p, b_stall_p;
  logic [ADDR_W-1:0] a_addr_p,  b_addr_p;
  logic [DATA_W-1:0] a_data_p,  b_data_p;
  initial begin
    a_stall_p = 1'b0;
    b_stall_p = 1'b0;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_stall_p && a_valid && (a_addr !== a_addr_p || a_data !== a_data_p)) begin
        errors++;
        $display("FAIL a_stable: addr=%0d data=%h, held addr=%0d data=%h", a_addr, a_data, a_addr_p, a_data_p);
      end
      if (b_stall_p && b_valid && (b_addr !== b_addr_p || b_data !== b_data_p)) begin
        errors++;
        $display("FAIL b_stable: addr=%0d data=%h, held addr=%0d data=%h", b_addr, b_data, b_addr_p, b_data_p);
      end
    end
    a_stall_p = a_valid & ~a_ready;
    b_stall_p = b_valid & ~b_ready;
    a_addr_p  = a_addr;
    a_data_p  = a_data;
    b_addr_p  = b_addr;
    b_data_p  = b_data;
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
    a_valid = av;
    a_addr  = aa;
    a_data  = ad;
    b_valid = bv;
    b_addr  = ba;
    b_data  = bd;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // A reset in the middle of traffic clears the outputs and the counter immediately.
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
`ifdef RF_WRITE_ARB_BYPASS_EN
    byp_raddr1 = '0;
    byp_raddr2 = '0;
`endif
    #12;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, rf_src_b, starve_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: we=%b waddr=%0d wdata=%h src_b=%b cnt=%0d, want all 0",
               rf_we, rf_waddr, rf_wdata, rf_src_b, starve_cnt);
    end
    rst_n = 1'b1;
    step();
    // Build a pending A write and a non-zero starvation count.
    drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd4, 32'h0000_0044);
    step();
    step();
    checks++;
    if (rf_we !== 1'b1 || starve_cnt !== 3'd2) begin
      errors++;
      $display("FAIL reset_pre: we=%b cnt=%0d, want we=1 cnt=2", rf_we, starve_cnt);
    end
    rst_n = 1'b0;
    idle();
    #1;
    checks++;
    if (rf_we !== 1'b0 || starve_cnt !== 3'd0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: we=%b cnt=%0d waddr=%0d wdata=%h, want all 0",
               rf_we, starve_cnt, rf_waddr, rf_wdata);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: we=%b, want 0", rf_we);
    end
  endtask

  // A alone: one-cycle latency, then eight back-to-back writes.
  task automatic test_a_only();
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL a_only_ready: a_ready=%b, want 1", a_ready);
    end
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF || rf_src_b !== 1'b0) begin
      errors++;
      $display("FAIL a_only_write: we=%b waddr=%0d wdata=%h src_b=%b, want 1/5/deadbeef/0",
               rf_we, rf_waddr, rf_wdata, rf_src_b);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(i + 10), 32'h1000 + 32'(i), 1'b0, '0, '0);
      step();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(i + 10) || rf_wdata !== 32'h1000 + 32'(i)) begin
        errors++;
        $display("FAIL a_b2b[%0d]: we=%b waddr=%0d wdata=%h, want 1/%0d/%h",
                 i, rf_we, rf_waddr, rf_wdata, i + 10, 32'h1000 + i);
      end
    end
    idle();
    step();
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd17 || rf_wdata !== 32'h1007) begin
      errors++;
      $display("FAIL a_idle_hold: we=%b waddr=%0d wdata=%h, want 0/17/1007", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  // Both valid every cycle: A wins four times, then B is forced through.
  task automatic test_contention();
    int exp_cnt;
    logic exp_b;
    drive(1'b1, 5'd7, 32'h0000_00AA, 1'b1, 5'd20, 32'h0000_0BBB);
    for (int k = 0; k < 10; k++) begin
      exp_cnt = k % 5;
      exp_b   = (exp_cnt == 4);
      #1;
      checks++;
      if (starve_cnt !== 3'(exp_cnt) || a_ready !== ~exp_b || b_ready !== exp_b) begin
        errors++;
        $display("FAIL contend_ready[%0d]: cnt=%0d a_ready=%b b_ready=%b, want %0d/%b/%b",
                 k, starve_cnt, a_ready, b_ready, exp_cnt, ~exp_b, exp_b);
      end
      step();
      checks++;
      if (rf_we !== 1'b1 || rf_src_b !== exp_b || rf_waddr !== (exp_b ? 5'd20 : 5'd7)) begin
        errors++;
        $display("FAIL contend_write[%0d]: we=%b src_b=%b waddr=%0d, want 1/%b/%0d",
                 k, rf_we, rf_src_b, rf_waddr, exp_b, exp_b ? 20 : 7);
      end
    end
    // Counter clears when B withdraws mid-starvation.
    step();
    step();
    checks++;
    if (starve_cnt !== 3'd2) begin
      errors++;
      $display("FAIL contend_cnt2: cnt=%0d, want 2", starve_cnt);
    end
    drive(1'b1, 5'd7, 32'h0000_00AA, 1'b0, '0, '0);
    step();
    checks++;
    if (starve_cnt !== 3'd0) begin
      errors++;
      $display("FAIL cnt_clear_on_drop: cnt=%0d, want 0", starve_cnt);
    end
    idle();
    step();
  endtask

  // Register 0 is accepted, but no write is enabled. rf_src_b still tracks the source.
  task automatic test_reg0();
    drive(1'b1, 5'd0, 32'h0000_1234, 1'b0, '0, '0);
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL reg0_ready: a_ready=%b, want 1", a_ready);
    end
    step();
    checks++;
    if (rf_we !== 1'b0 || rf_src_b !== 1'b0) begin
      errors++;
      $display("FAIL reg0_a: we=%b src_b=%b, want 0/0", rf_we, rf_src_b);
    end
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_5678);
    #1;
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL reg0_b_ready: b_ready=%b, want 1", b_ready);
    end
    step();
    checks++;
    if (rf_we !== 1'b0 || rf_src_b !== 1'b1) begin
      errors++;
      $display("FAIL reg0_b: we=%b src_b=%b, want 0/1", rf_we, rf_src_b);
    end
    idle();
    step();
  endtask

  // Same address from both sides: the A write lands first, then the B write.
  task automatic test_same_addr();
    drive(1'b1, 5'd8, 32'd1, 1'b1, 5'd8, 32'd2);
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL same_ready: a_ready=%b b_ready=%b, want 1/0", a_ready, b_ready);
    end
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'd1 || rf_src_b !== 1'b0) begin
      errors++;
      $display("FAIL same_first: we=%b waddr=%0d wdata=%0d src_b=%b, want 1/8/1/0",
               rf_we, rf_waddr, rf_wdata, rf_src_b);
    end
    drive(1'b0, '0, '0, 1'b1, 5'd8, 32'd2);
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'd2 || rf_src_b !== 1'b1) begin
      errors++;
      $display("FAIL same_second: we=%b waddr=%0d wdata=%0d src_b=%b, want 1/8/2/1",
               rf_we, rf_waddr, rf_wdata, rf_src_b);
    end
    idle();
    step();
    checks++;
    if (rf_we !== 1'b0 || starve_cnt !== 3'd0) begin
      errors++;
      $display("FAIL same_idle: we=%b cnt=%0d, want 0/0", rf_we, starve_cnt);
    end
  endtask

`ifdef RF_WRITE_ARB_BYPASS_EN
  // Forwarding hits match only the write that is live on the port.
  task automatic test_bypass();
    drive(1'b1, 5'd9, 32'h0000_0909, 1'b0, '0, '0);
    step();
    idle();
    byp_raddr1 = 5'd9;
    byp_raddr2 = 5'd10;
    #1;
    checks++;
    if (byp_hit1 !== 1'b1 || byp_hit2 !== 1'b0) begin
      errors++;
      $display("FAIL byp_hit: hit1=%b hit2=%b, want 1/0", byp_hit1, byp_hit2);
    end
    drive(1'b1, 5'd0, 32'h0000_0001, 1'b0, '0, '0);
    step();
    idle();
    byp_raddr1 = 5'd0;
    byp_raddr2 = 5'd0;
    #1;
    checks++;
    if (byp_hit1 !== 1'b0 || byp_hit2 !== 1'b0) begin
      errors++;
      $display("FAIL byp_reg0: hit1=%b hit2=%b, want 0/0", byp_hit1, byp_hit2);
    end
    step();
  endtask
`endif

  // Test sequence and the final report.
  initial begin
    test_reset();
    test_a_only();
    test_contention();
    test_reg0();
    test_same_addr();
`ifdef RF_WRITE_ARB_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
